// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: 16-bit word count header, then LSB-first 32-bit words written to imem from address 0.
// Write strobe one cycle after a word's 4th byte; never backpressures mid-stream; core released RESET_HOLD cycles after last write.
module imem_boot_loader #(
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 256,
   parameter int RESET_HOLD = 4
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      HOLD,
      RUN,
      ERR
   } state_t;

   localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);

   state_t              state;
   state_t              state_nxt;
   logic [15:0]         len_q;
   logic [23:0]         word_buf;
   logic [1:0]          byte_cnt;
   logic [ADDR_W:0]     word_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                xfer;
   logic                word_fire;
   logic [16:0]         len_full;
   logic [16:0]         word_cnt_ext;

   // Full header value as it completes in LEN_HI (high byte still on the bus).
   assign len_full     = {1'b0, in_data, len_q[7:0]};
   assign word_cnt_ext = 17'(word_cnt);
   assign xfer         = in_valid & in_ready;
   assign word_fire    = xfer && (state == DATA) && (byte_cnt == 2'd3);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         LEN_LO: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (len_full == 17'd0)
                  state_nxt = HOLD;
               else if (len_full > DEPTH_L)
                  state_nxt = ERR;
               else
                  state_nxt = DATA;
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (in_valid && (byte_cnt == 2'd3) && (word_cnt_ext + 17'd1 == {1'b0, len_q}))
               state_nxt = HOLD;
         end
         HOLD: begin
            if (hold_cnt == HOLD_LAST) state_nxt = RUN;
         end
         RUN:     state_nxt = RUN;
         ERR:     state_nxt = ERR;
         default: state_nxt = LEN_LO;
      endcase
      if (rst) in_ready = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state      <= LEN_LO;
         len_q      <= 16'd0;
         word_buf   <= 24'd0;
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         hold_cnt   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state   <= state_nxt;
         imem_we <= word_fire;

         if (xfer && (state == LEN_LO)) len_q[7:0]  <= in_data;
         if (xfer && (state == LEN_HI)) len_q[15:8] <= in_data;

         if (xfer && (state == DATA)) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    word_buf[7:0]   <= in_data;
               2'd1:    word_buf[15:8]  <= in_data;
               2'd2:    word_buf[23:16] <= in_data;
               default: ;
            endcase
         end

         // Fourth byte bypasses the buffer so the word lands one cycle after it.
         if (word_fire) begin
            imem_wdata <= {in_data, word_buf};
            imem_addr  <= word_cnt[ADDR_W-1:0];
            word_cnt   <= word_cnt + 1'b1;
         end

         hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
         core_rst <= (state_nxt != RUN);
         done     <= (state_nxt == RUN);
         err      <= (state_nxt == ERR);
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed + randomized bench for imem_boot_loader; expected writes and release timing derived from the byte stream.
module tb_imem_boot_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;
   localparam int RH     = 4;

   logic              clock = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              err;

   imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_HOLD(RH)) dut (
      .clock      (clock),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [7:0]  stream[$];
   int          xfer_edges[$];
   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_edge[$];
   bit          done_seen = 0;
   int          done_edge = 0;

   // Observer: sampled mid-cycle; a handshake seen here completes at the next edge.
   always @(negedge clock) begin
      if (rst) begin
         xfer_edges.delete();
         wr_addr.delete();
         wr_data.delete();
         wr_edge.delete();
         done_seen = 0;
         done_edge = 0;
      end else begin
         if (in_valid && in_ready) xfer_edges.push_back(cyc + 1);
         if (imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_edge.push_back(cyc);
         end
         if (done && !done_seen) begin
            done_seen = 1;
            done_edge = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut(input string tag);
      @(posedge clock); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk({tag, "_rst_ready"}, in_ready, 1'b0);
      chk({tag, "_rst_we"}, imem_we, 1'b0);
      chk({tag, "_rst_addr"}, imem_addr, 0);
      chk({tag, "_rst_wdata"}, imem_wdata, 0);
      chk({tag, "_rst_corerst"}, core_rst, 1'b1);
      chk({tag, "_rst_done_err"}, {done, err}, 2'b00);
      @(posedge clock); #1;
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      in_valid = 1'b1;
      in_data  = b;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         ok = (in_ready === 1'b1);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic offer_bytes(input int ncyc);
      in_valid = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         in_data = 8'($urandom);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic build(input int hdr, input int nwords);
      stream.delete();
      stream.push_back(8'(hdr % 256));
      stream.push_back(8'(hdr / 256));
      for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
   endtask

   // Plays the current stream (legal length) and checks writes, timing and final status.
   task automatic run_stream(input string tag, input int maxgap);
      int n;
      bit ok;
      logic [31:0] w;
      reset_dut(tag);
      n  = int'(stream[0]) + 256 * int'(stream[1]);
      ok = 1;
      for (int i = 0; i < stream.size() && ok; i++)
         send_byte(stream[i], $urandom_range(0, maxgap), ok);
      chk({tag, "_handshake"}, ok, 1'b1);
      for (int i = 0; i < RH + 10 && !done_seen; i++) @(negedge clock);
      chk({tag, "_done_seen"}, done_seen, 1'b1);
      chk({tag, "_nxfer"}, xfer_edges.size(), stream.size());
      chk({tag, "_nwrites"}, wr_data.size(), n);
      for (int k = 0; k < n && k < wr_data.size(); k++) begin
         w = 32'(stream[2 + 4*k]) + (32'(stream[3 + 4*k]) << 8)
           + (32'(stream[4 + 4*k]) << 16) + (32'(stream[5 + 4*k]) << 24);
         chk($sformatf("%s_addr%0d", tag, k), wr_addr[k], k);
         chk($sformatf("%s_data%0d", tag, k), wr_data[k], w);
         if (4*k + 5 < xfer_edges.size())
            chk($sformatf("%s_wedge%0d", tag, k), wr_edge[k], xfer_edges[4*k + 5]);
      end
      if (xfer_edges.size() > 0)
         chk({tag, "_release_edge"}, done_edge, xfer_edges[xfer_edges.size() - 1] + RH);
      chk({tag, "_corerst"}, core_rst, 1'b0);
      chk({tag, "_err"}, err, 1'b0);
      chk({tag, "_ready_run"}, in_ready, 1'b0);
   endtask

   task automatic run_oversize(input string tag, input int hdr);
      bit ok;
      reset_dut(tag);
      send_byte(8'(hdr % 256), 0, ok);
      chk({tag, "_hs_lo"}, ok, 1'b1);
      send_byte(8'(hdr / 256), 0, ok);
      chk({tag, "_hs_hi"}, ok, 1'b1);
      offer_bytes(12);
      @(negedge clock);
      chk({tag, "_err"}, err, 1'b1);
      chk({tag, "_ready"}, in_ready, 1'b0);
      chk({tag, "_corerst"}, core_rst, 1'b1);
      chk({tag, "_done"}, {done, done_seen}, 2'b00);
      chk({tag, "_nwrites"}, wr_data.size(), 0);
      chk({tag, "_nxfer"}, xfer_edges.size(), 2);
   endtask

   initial begin
      int nx;
      int nw;
      bit ok;
      logic [7:0] t1[10];
      t1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

      // T1: two-word program, back to back
      stream.delete();
      foreach (t1[i]) stream.push_back(t1[i]);
      run_stream("t1", 0);
      if (wr_data.size() == 2) begin
         chk("t1_word0_const", wr_data[0], 32'h0000_0013);
         chk("t1_word1_const", wr_data[1], 32'h0010_0093);
      end

      // T6: extra bytes after RUN are refused
      nx = xfer_edges.size();
      nw = wr_data.size();
      offer_bytes(10);
      @(negedge clock);
      chk("t6_nxfer", xfer_edges.size(), nx);
      chk("t6_nwrites", wr_data.size(), nw);
      chk("t6_done", done, 1'b1);
      chk("t6_corerst", core_rst, 1'b0);

      // T2: empty program
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      run_stream("t2", 0);

      // T3: oversize header, directed and random
      run_oversize("t3", 16'h0101);
      run_oversize("t3r", $urandom_range(DEPTH + 1, 65535));

      // T4: T1 stream with random valid gaps
      stream.delete();
      foreach (t1[i]) stream.push_back(t1[i]);
      run_stream("t4", 3);

      // T5: reset after header + 2 data bytes, then full T1
      reset_dut("t5a");
      for (int i = 0; i < 4; i++) send_byte(t1[i], 0, ok);
      run_stream("t5", 1);

      // Random programs with random gaps
      for (int r = 0; r < 4; r++) begin
         nw = $urandom_range(1, 8);
         build(nw, nw);
         run_stream($sformatf("rnd%0d", r), 3);
      end

      // Boundary: N == DEPTH must not wrap the word counter early
      build(DEPTH, DEPTH);
      run_stream("full", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
